// File: rtl/apu_pwm_capture.sv
// Receive end of the APU 1-bit PWM audio line: measures duty and rising edges over
// fixed 2**WINDOW_LOG2-cycle windows and offers each result on a valid/ready port.
module apu_pwm_capture #(
    parameter int WINDOW_LOG2 = 10,
    parameter int SAMPLE_W    = 8,
    parameter int EDGE_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic                sample_ready,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample,
    output logic [EDGE_W-1:0]   edges,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int SHIFT = WINDOW_LOG2 - SAMPLE_W;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic [0:0]             r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_prev;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [WINDOW_LOG2:0]   r_high_cnt;
    logic [EDGE_W-1:0]      r_edge_cnt;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_terminal;
    logic                   w_measuring;
    logic                   w_arrive;
    logic [WINDOW_LOG2:0]   w_total;
    logic [EDGE_W:0]        w_edge_sum;
    logic [EDGE_W-1:0]      w_edge_sat;
    logic [SAMPLE_W:0]      w_shifted;
    logic [SAMPLE_W-1:0]    w_sample_sat;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others (the sync chain depends on this).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_s         = r_sync2;
    assign w_rise      = r_sync2 & ~r_prev;
    assign w_terminal  = &r_win_cnt;
    assign w_measuring = (r_state == ST_MEASURE) && en;
    assign w_arrive    = w_measuring && w_terminal;

    // Totals include the current cycle so the terminal cycle is never lost.
    assign w_total      = r_high_cnt + {{WINDOW_LOG2{1'b0}}, w_s};
    assign w_edge_sum   = {1'b0, r_edge_cnt} + {{EDGE_W{1'b0}}, w_rise};
    assign w_edge_sat   = w_edge_sum[EDGE_W] ? {EDGE_W{1'b1}} : w_edge_sum[EDGE_W-1:0];
    assign w_shifted    = w_total[WINDOW_LOG2:SHIFT];
    assign w_sample_sat = w_shifted[SAMPLE_W] ? {SAMPLE_W{1'b1}} : w_shifted[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_win_cnt  <= '0;
            r_high_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_state <= en ? ST_MEASURE : ST_IDLE;
            if (w_measuring && !w_terminal) begin
                r_win_cnt  <= r_win_cnt + WINDOW_LOG2'(1);
                r_high_cnt <= w_total;
                r_edge_cnt <= w_edge_sat;
            end else begin
                // Idle, aborted partial window, or window wrap: restart from zero.
                r_win_cnt  <= '0;
                r_high_cnt <= '0;
                r_edge_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            sample       <= '0;
            edges        <= '0;
        end else if (w_arrive) begin
            sample_valid <= 1'b1;
            sample       <= w_sample_sat;
            edges        <= w_edge_sat;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Clear has priority over an overwrite landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end else if (w_arrive && sample_valid && !sample_ready) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apu_pwm_capture.sv
// Directed bench for apu_pwm_capture: known PWM patterns over whole windows with
// hand-computed duty/edge results, handshake, overrun, abort and reset behaviour.
module tb_apu_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pwm_in;
    logic       sample_ready;
    logic       clr_overrun;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] edges;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int pwm_per  = 1;
    int pwm_hi   = 0;
    int ph       = 0;

    apu_pwm_capture #(
        .WINDOW_LOG2(10),
        .SAMPLE_W   (8),
        .EDGE_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .sample      (sample),
        .edges       (edges),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Advance n clocks; inputs change 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pwm_in = (ph < pwm_hi);
            ph = (ph + 1) % pwm_per;
        end
    endtask

    task automatic set_pwm(input int per, input int hi);
        pwm_per = per;
        pwm_hi  = hi;
        ph      = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; sample_ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        n_checks++; if (sample !== 8'h00) begin n_errors++; $display("FAIL reset_sample: got %h want 00", sample); end
        n_checks++; if (edges !== 8'h00) begin n_errors++; $display("FAIL reset_edges: got %h want 00", edges); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
        tick(2);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b want 0", sample_valid); end
    endtask

    task automatic test_low_window;
        set_pwm(1, 0);
        tick(4);
        en = 1'b1;
        tick(1024);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL low_early_valid: got %b want 0", sample_valid); end
        tick(1);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL low_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h00) begin n_errors++; $display("FAIL low_sample: got %h want 00", sample); end
        n_checks++; if (edges !== 8'h00) begin n_errors++; $display("FAIL low_edges: got %h want 00", edges); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL low_overrun: got %b want 0", overrun); end
        sample_ready = 1'b1;
        tick(1);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL low_consume: got %b want 0", sample_valid); end
        n_checks++; if (sample !== 8'h00) begin n_errors++; $display("FAIL low_hold: got %h want 00", sample); end
        en = 1'b0;
        tick(4);
    endtask

    task automatic test_high_from_reset;
        sample_ready = 1'b0;
        set_pwm(1, 1);
        pwm_in = 1'b1;
        rst_n = 1'b0;
        en = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1025);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL high1_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'hFF) begin n_errors++; $display("FAIL high1_sample: got %h want ff", sample); end
        n_checks++; if (edges !== 8'h01) begin n_errors++; $display("FAIL high1_edges: got %h want 01", edges); end
        sample_ready = 1'b1;
        tick(1);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL high1_consume: got %b want 0", sample_valid); end
        tick(1023);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL high2_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'hFF) begin n_errors++; $display("FAIL high2_sample: got %h want ff", sample); end
        n_checks++; if (edges !== 8'h00) begin n_errors++; $display("FAIL high2_edges: got %h want 00", edges); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL high2_overrun: got %b want 0", overrun); end
        en = 1'b0;
        tick(4);
    endtask

    task automatic test_duty_25;
        set_pwm(16, 4);
        tick(20);
        en = 1'b1;
        tick(1025);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL d25a_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h40) begin n_errors++; $display("FAIL d25a_sample: got %h want 40", sample); end
        n_checks++; if (edges !== 8'd64) begin n_errors++; $display("FAIL d25a_edges: got %0d want 64", edges); end
        tick(1024);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL d25b_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h40) begin n_errors++; $display("FAIL d25b_sample: got %h want 40", sample); end
        n_checks++; if (edges !== 8'd64) begin n_errors++; $display("FAIL d25b_edges: got %0d want 64", edges); end
        tick(1);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL d25b_consume: got %b want 0", sample_valid); end
        en = 1'b0;
        sample_ready = 1'b0;
        tick(4);
    endtask

    task automatic test_overrun;
        en = 1'b1;
        tick(1025);
        n_checks++; if (sample !== 8'h40) begin n_errors++; $display("FAIL ovr_first_sample: got %h want 40", sample); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_first_overrun: got %b want 0", overrun); end
        en = 1'b0;
        set_pwm(16, 8);
        tick(20);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_pending_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h40) begin n_errors++; $display("FAIL ovr_pending_sample: got %h want 40", sample); end
        en = 1'b1;
        tick(1025);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h80) begin n_errors++; $display("FAIL ovr_sample: got %h want 80", sample); end
        n_checks++; if (edges !== 8'd64) begin n_errors++; $display("FAIL ovr_edges: got %0d want 64", edges); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        clr_overrun = 1'b1;
        tick(1);
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        tick(1023);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_clrwin_valid: got %b want 1", sample_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clr_wins: got %b want 0", overrun); end
        clr_overrun = 1'b0;
        sample_ready = 1'b1;
        tick(1);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_consume: got %b want 0", sample_valid); end
        n_checks++; if (sample !== 8'h80) begin n_errors++; $display("FAIL ovr_hold: got %h want 80", sample); end
        en = 1'b0;
        sample_ready = 1'b0;
        tick(4);
    endtask

    task automatic test_en_abort;
        en = 1'b1;
        tick(501);
        en = 1'b0;
        tick(10);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL abort_no_result: got %b want 0", sample_valid); end
        en = 1'b1;
        tick(1024);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL abort_early: got %b want 0", sample_valid); end
        tick(1);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL abort_full_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h80) begin n_errors++; $display("FAIL abort_sample: got %h want 80", sample); end
    endtask

    task automatic test_reset_mid;
        tick(300);
        rst_n = 1'b0;
        #2;
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b want 0", sample_valid); end
        n_checks++; if (sample !== 8'h00) begin n_errors++; $display("FAIL rstmid_sample: got %h want 00", sample); end
        n_checks++; if (edges !== 8'h00) begin n_errors++; $display("FAIL rstmid_edges: got %h want 00", edges); end
        tick(2);
        rst_n = 1'b1;
        en = 1'b0;
        tick(2);
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_after: got %b want 0", sample_valid); end
    endtask

    task automatic test_period2;
        set_pwm(2, 1);
        tick(10);
        en = 1'b1;
        tick(1025);
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL p2_valid: got %b want 1", sample_valid); end
        n_checks++; if (sample !== 8'h80) begin n_errors++; $display("FAIL p2_sample: got %h want 80", sample); end
        n_checks++; if (edges !== 8'hFF) begin n_errors++; $display("FAIL p2_edges_sat: got %h want ff", edges); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL p2_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_low_window();
        test_high_from_reset();
        test_duty_25();
        test_overrun();
        test_en_abort();
        test_reset_mid();
        test_period2();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
